// File: rtl/data_sink_array.sv
// data_sink_array: NUM_STREAMS independent sinks. Each transaction is either discarded or
// forwarded through a 2-entry registered skid stage, as set by per-stream queued decisions
// that arrive on one broadcast config stream.
// Build option: define DATA_SINK_ARRAY_STATS_EN to add per-stream saturating drop counters
// and the stats_clear / drop_beats ports.
module data_sink_array #(
  parameter int unsigned NUM_STREAMS  = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_ELEMENTS = 8,
  parameter int unsigned CFG_DEPTH    = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        cfg_valid,
  output logic                                        cfg_ready,
  input  logic [NUM_STREAMS-1:0]                      cfg_data,
  input  logic [NUM_STREAMS-1:0]                      in_valid,
  output logic [NUM_STREAMS-1:0]                      in_ready,
  input  logic [NUM_STREAMS-1:0]                      in_last,
  input  logic [NUM_STREAMS*NUM_ELEMENTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_STREAMS*NUM_ELEMENTS-1:0]         in_keep,
  output logic [NUM_STREAMS-1:0]                      out_valid,
  input  logic [NUM_STREAMS-1:0]                      out_ready,
  output logic [NUM_STREAMS-1:0]                      out_last,
  output logic [NUM_STREAMS*NUM_ELEMENTS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_STREAMS*NUM_ELEMENTS-1:0]         out_keep
`ifdef DATA_SINK_ARRAY_STATS_EN
  ,
  input  logic                                        stats_clear,
  output logic [NUM_STREAMS*32-1:0]                   drop_beats
`endif
);

  localparam int unsigned BEAT_W = NUM_ELEMENTS * DATA_WIDTH;
  localparam int unsigned KEEP_W = NUM_ELEMENTS;
  localparam int unsigned PTR_W  = $clog2(CFG_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [BEAT_W-1:0] data;
  } beat_t;

  logic [NUM_STREAMS-1:0] fifo_full;
  logic                   cfg_fire;

  // A decision word is taken only when every stream's queue has room; nothing during reset.
  assign cfg_ready = !rst && (fifo_full == '0);
  assign cfg_fire  = cfg_valid && cfg_ready;

  for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_stream
    logic [CFG_DEPTH-1:0] dq;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     dcnt;
    logic                 fifo_empty;
    logic                 head_discard;
    logic                 in_fire;
    logic                 last_pop;
    beat_t                in_beat;
    beat_t                e0;
    beat_t                e1;
    logic [1:0]           sk_cnt;
    logic                 skid_full;
    logic                 fwd_push;
    logic                 out_pop;

    assign fifo_empty   = (dcnt == '0);
    assign fifo_full[g] = (dcnt == CNT_W'(CFG_DEPTH));
    assign head_discard = dq[rd_ptr];
    assign skid_full    = (sk_cnt == 2'd2);
    assign in_ready[g]  = !rst && !fifo_empty && (head_discard || !skid_full);
    assign in_fire      = in_valid[g] && in_ready[g];
    assign last_pop     = in_fire && in_last[g];
    assign fwd_push     = in_fire && !head_discard;
    assign out_pop      = out_valid[g] && out_ready[g];
    assign in_beat      = '{last: in_last[g],
                            keep: in_keep[g*KEEP_W +: KEEP_W],
                            data: in_data[g*BEAT_W +: BEAT_W]};

    // Decision queue: pushed by every accepted config word, popped by each accepted last beat.
    always_ff @(posedge clk) begin
      if (rst) begin
        dq     <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        dcnt   <= '0;
      end else begin
        if (cfg_fire) begin
          dq[wr_ptr] <= cfg_data[g];
          wr_ptr     <= wr_ptr + PTR_W'(1);
        end
        if (last_pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({cfg_fire, last_pop})
          2'b10:   dcnt <= dcnt + CNT_W'(1);
          2'b01:   dcnt <= dcnt - CNT_W'(1);
          default: dcnt <= dcnt;
        endcase
      end
    end

    // Two-entry skid: e0 drives the outputs, e1 holds a beat that arrived during a stall.
    always_ff @(posedge clk) begin
      if (rst) begin
        sk_cnt <= 2'd0;
        e0     <= '0;
        e1     <= '0;
      end else begin
        case ({fwd_push, out_pop})
          2'b10: begin
            if (sk_cnt == 2'd0) e0 <= in_beat;
            else                e1 <= in_beat;
            sk_cnt <= sk_cnt + 2'd1;
          end
          2'b01: begin
            if (sk_cnt == 2'd2) e0 <= e1;
            sk_cnt <= sk_cnt - 2'd1;
          end
          2'b11: begin
            if (sk_cnt == 2'd2) begin
              e0 <= e1;
              e1 <= in_beat;
            end else begin
              e0 <= in_beat;
            end
          end
          default: sk_cnt <= sk_cnt;
        endcase
      end
    end

    assign out_valid[g]                  = (sk_cnt != 2'd0);
    assign out_last[g]                   = e0.last;
    assign out_keep[g*KEEP_W +: KEEP_W]  = e0.keep;
    assign out_data[g*BEAT_W +: BEAT_W]  = e0.data;

`ifdef DATA_SINK_ARRAY_STATS_EN
    logic [31:0] drop_cnt;

    // Saturating count of discarded beats; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
      if (rst || stats_clear) begin
        drop_cnt <= '0;
      end else if (in_fire && head_discard && (drop_cnt != 32'hFFFF_FFFF)) begin
        drop_cnt <= drop_cnt + 32'd1;
      end
    end

    assign drop_beats[g*32 +: 32] = drop_cnt;
`endif
  end

endmodule

// File: doc/data_sink_array.md
# data_sink_array

Multi-stream successor to the single-stream data sink. Sits on NUM_STREAMS parallel ndata streams and decides, per stream and per transaction, whether to discard the transaction or forward it through a registered output stage. Per-transaction decisions arrive on one broadcast config stream and are queued per stream, so several transactions' decisions can be preloaded. Optional per-stream drop statistics are available.

## Interface
- NUM_STREAMS, 4, number of independent data streams (1..16)
- DATA_WIDTH, 32, bits per element
- NUM_ELEMENTS, 8, elements per beat
- CFG_DEPTH, 4, per-stream decision queue depth (power of two, ≥2)
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  decision word valid
- cfg_ready  out  1  decision word accepted when cfg_valid && cfg_ready
- cfg_data  in  NUM_STREAMS  bit i = 1: discard next transaction of stream i; 0: forward
- in_valid / in_ready / in_last  in/out/in  NUM_STREAMS each  per-stream input handshake
- in_data  in  NUM_STREAMS*NUM_ELEMENTS*DATA_WIDTH  stream i at slice i
- in_keep  in  NUM_STREAMS*NUM_ELEMENTS  per-element keep
- out_valid / out_ready / out_last  out/in/out  NUM_STREAMS each  per-stream output handshake
- out_data, out_keep  out  same widths as input  registered payload
- stats_clear  in  1  clears drop counters (stats build only)
- drop_beats  out  NUM_STREAMS*32  per-stream discarded-beat count (stats build only)

## Operation
- Per stream: decision FIFO (CFG_DEPTH entries, 1 bit) + 2-entry skid buffer on the output.
- Config: cfg_ready = no stream FIFO full. On acceptance bit i is pushed into FIFO i in the same cycle for all streams. No full-and-pop bypass: a full FIFO holds cfg_ready low even if popping that cycle.
- Stream i with FIFO empty: in_ready[i]=0, nothing forwarded.
- Head = discard: in_ready[i]=1 unconditionally; beats consumed, never reach output.
- Head = forward: in_ready[i] = skid buffer not full; accepted beats enter skid buffer unchanged (data, keep, last).
- Accepted beat with in_last[i]=1 pops FIFO i; next beat uses the next decision.
- Streams fully independent; a stall on one output never affects another's in_ready.
- Beats with all keep bits 0 are treated like any other beat.

## Timing
- Reset: cfg_ready=0 during reset, 1 from the first cycle after; in_ready=0, out_valid=0, out_last=0, out_data/out_keep=0, FIFOs empty, counters 0.
- Decision accepted in cycle T is usable by its stream from T+1; in_ready may first assert in T+1.
- Forward latency: input accepted in cycle T appears on out_* in T+1. Full throughput of 1 beat/cycle per stream with out_ready held high.
- Last beat popping the FIFO in T: the next decision governs in_ready from T+1. Back-to-back transactions with no bubble if the FIFO held ≥2 entries.
- out_* stable while out_valid && !out_ready. in_ready depends on FIFO state and skid occupancy only, never on in_valid.
- Reset mid-transaction: queued decisions and buffered beats dropped; the next transaction needs a new decision.

## Configuration
- DATA_SINK_ARRAY_STATS_EN defined: per-stream 32-bit counter increments per accepted discarded beat, saturates at 0xFFFFFFFF, zeroed by stats_clear (clear wins over a same-cycle increment); drop_beats and stats_clear present.
- Undefined: no counters; drop_beats and stats_clear ports absent.

## Test plan
- Reset, cfg 4'b0000, stream 0 sends 3 beats (last on 3rd), out_ready=1 -> identical 3 beats on out 0 at one-cycle latency, FIFO 0 empty afterwards, in_ready[0]=0.
- cfg 4'b0001 then 4'b0000; stream 0 sends two 2-beat transactions back-to-back -> first transaction absent from output, second forwarded, no bubble between them on in_ready[0].
- Push 4 decisions without traffic (CFG_DEPTH=4) -> cfg_ready=0 after the 4th; accept one stream-0 last beat only -> cfg_ready stays 0 (stream 1 still full).
- Forward on stream 2, out_ready[2]=0 for 5 cycles -> in_ready[2] drops after 2 accepted beats, out_data stable; streams 0/1 in discard keep in_ready=1.
- Stats build: discard 10 beats on stream 3, pulse stats_clear on the cycle of the 10th -> drop_beats[3]=0 afterwards; 7 further discarded beats -> 7.
- Assert rst in the middle of a forwarded transaction -> out_valid=0 next cycle, cfg_ready=0 during reset and 1 the cycle after, in_ready=0 until a new decision is accepted.
